// File: rtl/card_match_ctrl.sv
// Card-flip game controller: latches the shuffled symbol map, accepts two selections per move,
// compares symbols, and tracks face-up/matched cards, pairs, moves and the win condition.
module card_match_ctrl #(
   parameter int unsigned FLIP_HOLD = 25_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   output logic        shuffle_start,
   input  logic [0:47] map_in,
   input  logic        map_done,
   input  logic        sel_valid,
   input  logic [3:0]  sel_idx,
   output logic        sel_ready,
   output logic [0:47] sym_map,
   output logic [15:0] face_up,
   output logic [15:0] matched,
   output logic [3:0]  pair_count,
   output logic [7:0]  move_count,
   output logic        game_won
);

   localparam int unsigned HOLD_W = (FLIP_HOLD > 1) ? $clog2(FLIP_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLIP_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHUFFLE,
      S_FIRST,
      S_SECOND,
      S_COMPARE,
      S_HOLD,
      S_WON
   } state_t;

   state_t            state;
   logic [3:0]        card_a;
   logic [3:0]        card_b;
   logic [HOLD_W-1:0] hold_cnt;
   logic [2:0]        sym [16];
   logic              sel_ok;
   logic              sym_eq;
   logic [15:0]       pair_bits;

   // Unpack the latched map into per-card symbols
   for (genvar g = 0; g < 16; g++) begin : g_sym
      assign sym[g] = sym_map[3*g +: 3];
   end

   assign sel_ok    = sel_valid && sel_ready && !face_up[sel_idx];
   assign sym_eq    = (sym[card_a] == sym[card_b]);
   assign pair_bits = (16'h0001 << card_a) | (16'h0001 << card_b);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         shuffle_start <= 1'b0;
         sel_ready     <= 1'b0;
         sym_map       <= '0;
         face_up       <= '0;
         matched       <= '0;
         pair_count    <= '0;
         move_count    <= '0;
         game_won      <= 1'b0;
         card_a        <= '0;
         card_b        <= '0;
         hold_cnt      <= '0;
      end else begin
         shuffle_start <= 1'b0;
         if (new_game) begin
            // Restart from any state; the old map stays until the next map_done
            state         <= S_SHUFFLE;
            shuffle_start <= 1'b1;
            sel_ready     <= 1'b0;
            face_up       <= '0;
            matched       <= '0;
            pair_count    <= '0;
            move_count    <= '0;
            game_won      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: ;
               S_SHUFFLE: begin
                  if (map_done) begin
                     sym_map   <= map_in;
                     sel_ready <= 1'b1;
                     state     <= S_FIRST;
                  end
               end
               S_FIRST: begin
                  if (sel_ok) begin
                     face_up[sel_idx] <= 1'b1;
                     card_a           <= sel_idx;
                     state            <= S_SECOND;
                  end
               end
               S_SECOND: begin
                  if (sel_ok) begin
                     face_up[sel_idx] <= 1'b1;
                     card_b           <= sel_idx;
                     if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                     sel_ready        <= 1'b0;
                     state            <= S_COMPARE;
                  end
               end
               S_COMPARE: begin
                  if (sym_eq) begin
                     matched    <= matched | pair_bits;
                     pair_count <= pair_count + 4'd1;
                     if (pair_count == 4'd7) begin
                        game_won <= 1'b1;
                        state    <= S_WON;
                     end else begin
                        sel_ready <= 1'b1;
                        state     <= S_FIRST;
                     end
                  end else begin
                     hold_cnt <= HOLD_LOAD;
                     state    <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (hold_cnt == '0) begin
                     face_up   <= face_up & ~pair_bits;
                     sel_ready <= 1'b1;
                     state     <= S_FIRST;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               S_WON: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
